// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared state encoding and constants for the instruction-fetch controller.
// The optional exception redirect is enabled by defining PC_CTRL_EXC_EN.
package pc_fetch_ctrl_pkg;

    localparam int PC_BUS = 32;
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        PCF_IDLE = 2'd0,
        PCF_REQ  = 2'd1,
        PCF_DROP = 2'd2
    } pcf_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_next_sel.sv
// Priority select of the redirect target: exception (PC_CTRL_EXC_EN only) > branch > jump.
// Targets are always word aligned.
module pc_next_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int PC_W = PC_BUS
`ifdef PC_CTRL_EXC_EN
    ,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_0180)
`endif
) (
`ifdef PC_CTRL_EXC_EN
    input  logic            exc,
`endif
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    output logic            redirect,
    output logic [PC_W-1:0] target
);

    always_comb begin
        redirect = 1'b0;
        target   = '0;
`ifdef PC_CTRL_EXC_EN
        if (exc) begin
            redirect = 1'b1;
            target   = EXC_VECTOR;
        end else
`endif
        if (br_taken) begin
            redirect = 1'b1;
            target   = br_target;
        end else if (jmp) begin
            redirect = 1'b1;
            target   = jmp_target;
        end
        target[1:0] = 2'b00;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer: req/ack to instruction memory, one-entry slot to decode.
// Define PC_CTRL_EXC_EN to add the exc_i port and the EXC_VECTOR redirect.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = PC_BUS,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef PC_CTRL_EXC_EN
    ,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_0180)
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               br_taken_i,
    input  logic [PC_W-1:0]    br_target_i,
    input  logic               jmp_i,
    input  logic [PC_W-1:0]    jmp_target_i,
`ifdef PC_CTRL_EXC_EN
    input  logic               exc_i,
`endif
    output logic               if_req_o,
    output logic [PC_W-1:0]    if_addr_o,
    input  logic               if_ack_i,
    input  logic [INSTR_W-1:0] if_rdata_i,
    output logic               inst_valid_o,
    output logic [INSTR_W-1:0] inst_o,
    output logic [PC_W-1:0]    inst_pc_o,
    input  logic               id_ready_i,
    output logic               flush_o
);

    pcf_state_t         state, state_next;
    logic [PC_W-1:0]    pc, pc_next;
    logic [PC_W-1:0]    held_addr, held_addr_next;
    logic               pending, pending_next;
    logic               slot_valid, slot_valid_next;
    logic [INSTR_W-1:0] slot_inst, slot_inst_next;
    logic [PC_W-1:0]    slot_pc, slot_pc_next;
    logic               flush, flush_next;
    logic               redirect;
    logic [PC_W-1:0]    redirect_target;
    logic               slot_open;

    pc_next_sel #(
        .PC_W       (PC_W)
`ifdef PC_CTRL_EXC_EN
        ,
        .EXC_VECTOR (EXC_VECTOR)
`endif
    ) u_next_sel (
`ifdef PC_CTRL_EXC_EN
        .exc        (exc_i),
`endif
        .br_taken   (br_taken_i),
        .br_target  (br_target_i),
        .jmp        (jmp_i),
        .jmp_target (jmp_target_i),
        .redirect   (redirect),
        .target     (redirect_target)
    );

    // A request, once raised, is held until acked; DROP keeps the stale address on the bus.
    assign slot_open    = !slot_valid || id_ready_i;
    assign if_req_o     = ((state == PCF_REQ) && (pending || slot_open)) || (state == PCF_DROP);
    assign if_addr_o    = (state == PCF_DROP) ? held_addr : pc;
    assign inst_valid_o = slot_valid;
    assign inst_o       = slot_inst;
    assign inst_pc_o    = slot_pc;
    assign flush_o      = flush;

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        held_addr_next  = held_addr;
        pending_next    = pending;
        slot_valid_next = slot_valid && !id_ready_i;
        slot_inst_next  = slot_inst;
        slot_pc_next    = slot_pc;
        flush_next      = redirect;

        if (redirect) begin
            pc_next         = redirect_target;
            slot_valid_next = 1'b0;
        end

        case (state)
            PCF_IDLE: state_next = PCF_REQ;
            PCF_REQ: begin
                if (redirect) begin
                    pending_next = 1'b0;
                    if (if_req_o && !if_ack_i) begin
                        state_next     = PCF_DROP;
                        held_addr_next = pc;
                    end
                end else if (if_req_o && if_ack_i) begin
                    slot_valid_next = 1'b1;
                    slot_inst_next  = if_rdata_i;
                    slot_pc_next    = pc;
                    pc_next         = pc + PC_W'(PC_INC);
                    pending_next    = 1'b0;
                end else begin
                    pending_next = if_req_o;
                end
            end
            PCF_DROP: begin
                pending_next = 1'b0;
                if (if_ack_i) begin
                    state_next = PCF_REQ;
                end
            end
            default: state_next = PCF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PCF_IDLE;
            pc         <= RESET_PC;
            held_addr  <= '0;
            pending    <= 1'b0;
            slot_valid <= 1'b0;
            slot_inst  <= '0;
            slot_pc    <= '0;
            flush      <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            held_addr  <= held_addr_next;
            pending    <= pending_next;
            slot_valid <= slot_valid_next;
            slot_inst  <= slot_inst_next;
            slot_pc    <= slot_pc_next;
            flush      <= flush_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: transaction-level model plus directed scenarios.
// Builds with or without PC_CTRL_EXC_EN.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        br_taken_i   = 1'b0;
    logic [31:0] br_target_i  = '0;
    logic        jmp_i        = 1'b0;
    logic [31:0] jmp_target_i = '0;
`ifdef PC_CTRL_EXC_EN
    logic        exc_i        = 1'b0;
`endif
    logic        if_req_o;
    logic [31:0] if_addr_o;
    logic        if_ack_i     = 1'b0;
    logic [31:0] if_rdata_i   = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        id_ready_i   = 1'b1;
    logic        flush_o;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          mem_delay = 0;
    int          wait_cnt = 0;
    logic        last_req = 1'b0;
    logic        last_ack = 1'b0;
    logic        rst_sampled = 1'b0;

    logic [31:0] fetch_log[$];
    logic [31:0] seen_pcs[$];
    int          run_lens[$];
    int          flush_cnt = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } slot_t;

    slot_t       exp_q[$];
    logic [31:0] exp_addr  = RESET_PC;
    logic [31:0] pend_addr = '0;
    logic        exp_flush = 1'b0;
    logic        stale     = 1'b0;
    logic        idle      = 1'b1;
    logic        pend_prev = 1'b0;
    int          run_len   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
`ifdef PC_CTRL_EXC_EN
        .exc_i        (exc_i),
`endif
        .if_req_o     (if_req_o),
        .if_addr_o    (if_addr_o),
        .if_ack_i     (if_ack_i),
        .if_rdata_i   (if_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .id_ready_i   (id_ready_i),
        .flush_o      (flush_o)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] logAt(input int i);
        if (i < fetch_log.size()) return fetch_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int countSeen(input logic [31:0] pc);
        int n = 0;
        foreach (seen_pcs[i]) if (seen_pcs[i] == pc) n++;
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks after mem_delay cycles of a held request, reset by the same rst.
    initial begin
        forever begin
            @(posedge clk);
            if (rst || !(last_req && !last_ack)) wait_cnt = 0;
            else wait_cnt++;
            #2;
            if_ack_i   = if_req_o && (wait_cnt >= mem_delay);
            if_rdata_i = memWord(if_addr_o);
            last_req   = if_req_o;
            last_ack   = if_ack_i;
        end
    end

    always @(posedge clk) rst_sampled = rst;

    // Per-cycle comparison against the transaction model.
    always @(negedge clk) begin : compare
        logic        redir;
        logic [31:0] tgt;
        logic        exp_req;
        slot_t       s;
        if (rst) begin
            if (rst_sampled) begin
                checkOutput("rst_req", 32'(if_req_o), 32'd0);
                checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);
                checkOutput("rst_flush", 32'(flush_o), 32'd0);
                checkOutput("rst_inst", inst_o, 32'd0);
                checkOutput("rst_inst_pc", inst_pc_o, 32'd0);
            end
            exp_q.delete();
            exp_addr  = RESET_PC;
            exp_flush = 1'b0;
            stale     = 1'b0;
            idle      = 1'b1;
            pend_prev = 1'b0;
            run_len   = 0;
        end else begin
            checkOutput("flush", 32'(flush_o), 32'(exp_flush));
            if (flush_o) flush_cnt++;
            checkOutput("valid", 32'(inst_valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                checkOutput("inst", inst_o, exp_q[0].inst);
                checkOutput("inst_pc", inst_pc_o, exp_q[0].pc);
            end
            if (inst_valid_o && id_ready_i) seen_pcs.push_back(inst_pc_o);

            if (pend_prev) begin
                checkOutput("req_hold", 32'(if_req_o), 32'd1);
                checkOutput("addr_hold", if_addr_o, pend_addr);
            end else begin
                exp_req = !idle && (exp_q.size() == 0 || id_ready_i);
                checkOutput("req_issue", 32'(if_req_o), 32'(exp_req));
                if (if_req_o) begin
                    checkOutput("fetch_addr", if_addr_o, exp_addr);
                    fetch_log.push_back(if_addr_o);
                    pend_addr = exp_addr;
                end
            end

            redir = br_taken_i || jmp_i;
            tgt   = br_taken_i ? br_target_i : jmp_target_i;
`ifdef PC_CTRL_EXC_EN
            if (exc_i) begin
                redir = 1'b1;
                tgt   = 32'h0000_0180;
            end
`endif
            tgt[1:0] = 2'b00;

            if (if_req_o) begin
                run_len++;
                if (if_ack_i) begin
                    run_lens.push_back(run_len);
                    run_len = 0;
                end
            end
            pend_prev = if_req_o && !if_ack_i;

            if (redir) begin
                exp_q.delete();
                exp_addr  = tgt;
                stale     = if_req_o && !if_ack_i;
                exp_flush = 1'b1;
            end else begin
                exp_flush = 1'b0;
                if (exp_q.size() != 0 && id_ready_i) void'(exp_q.pop_front());
                if (if_req_o && if_ack_i) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        s.inst = memWord(pend_addr);
                        s.pc   = pend_addr;
                        exp_q.push_back(s);
                        exp_addr = pend_addr + 32'd4;
                    end
                end
            end
            idle = 1'b0;
        end
    end

    task automatic applyStimulus(input logic br, input logic [31:0] bt, input logic jmp, input logic [31:0] jt);
        @(posedge clk); #1;
        br_taken_i   = br;
        br_target_i  = bt;
        jmp_i        = jmp;
        jmp_target_i = jt;
        @(negedge clk); #1;
        fetch_log.delete();
        @(posedge clk); #1;
        br_taken_i = 1'b0;
        jmp_i      = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitLog(input int n, input int limit);
        for (int i = 0; i < limit && fetch_log.size() < n; i++) begin
            @(negedge clk); #1;
        end
        checkOutput("wait_fetch", 32'(fetch_log.size() >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        fetch_log.delete();

        // zero-wait stream: 0x0, 0x4, 0x8 on consecutive cycles
        @(negedge clk); #1;
        checkOutput("idle_req", 32'(if_req_o), 32'd0);
        repeat (3) begin
            @(negedge clk); #1;
        end
        checkOutput("seq_count", 32'(fetch_log.size()), 32'd3);
        checkOutput("seq_addr0", logAt(0), 32'h0000_0000);
        checkOutput("seq_addr1", logAt(1), 32'h0000_0004);
        checkOutput("seq_addr2", logAt(2), 32'h0000_0008);
        checkOutput("seq_inst_pc", inst_pc_o, 32'h0000_0004);
        checkOutput("seq_inst", inst_o, 32'hFFFB_0004);

        // three wait states: request held four cycles
        @(posedge clk); #1;
        mem_delay = 3;
        run_lens.delete();
        seen_pcs.delete();
        for (int i = 0; i < 20 && run_lens.size() == 0; i++) begin
            @(negedge clk); #1;
        end
        checkOutput("delay_run", 32'(run_lens.size() > 0 ? run_lens[0] : 0), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("delay_single", 32'(countSeen(32'h0000_000C)), 32'd1);
        mem_delay = 0;
        repeat (3) @(posedge clk);
        #1;

        // decode stall: no new requests while the slot is full
        id_ready_i = 1'b0;
        fetch_log.delete();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("stall_noreq", 32'(fetch_log.size()), 32'd0);
        id_ready_i = 1'b1;
        @(negedge clk); #1;
        checkOutput("stall_resume", 32'(fetch_log.size()), 32'd1);

        // branch while the 0x8 request is outstanding
        mem_delay = 3;
        doReset();
        fetch_log.delete();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (fetch_log.size() > 0 && fetch_log[fetch_log.size()-1] == 32'h8) break;
        end
        checkOutput("drop_found8", logAt(fetch_log.size() - 1), 32'h0000_0008);
        flush_cnt = 0;
        seen_pcs.delete();
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        waitLog(1, 20);
        checkOutput("drop_next", logAt(0), 32'h0000_0100);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("drop_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("drop_no8", 32'(countSeen(32'h0000_0008)), 32'd0);
        checkOutput("drop_got100", 32'(countSeen(32'h0000_0100)), 32'd1);

        // branch beats jump
        mem_delay = 0;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200);
        @(negedge clk); #1;
        checkOutput("prio_br", logAt(0), 32'h0000_0100);

`ifdef PC_CTRL_EXC_EN
        @(posedge clk); #1;
        br_taken_i = 1'b1; br_target_i = 32'h100;
        jmp_i = 1'b1; jmp_target_i = 32'h200;
        exc_i = 1'b1;
        @(negedge clk); #1;
        fetch_log.delete();
        @(posedge clk); #1;
        br_taken_i = 1'b0; jmp_i = 1'b0; exc_i = 1'b0;
        @(negedge clk); #1;
        checkOutput("prio_exc", logAt(0), 32'h0000_0180);
`endif

        // PC wrap, with unaligned target bits forced to zero
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        @(negedge clk); #1;
        checkOutput("wrap_top", logAt(0), 32'hFFFF_FFFC);
        checkOutput("wrap_zero", logAt(1), 32'h0000_0000);

        // reset while in DROP
        @(posedge clk); #1;
        mem_delay = 3;
        fetch_log.delete();
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checkOutput("rst_drop_req", 32'(if_req_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fetch_log.delete();
        waitLog(1, 20);
        checkOutput("rst_restart", logAt(0), RESET_PC);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
